mem_stage: RTL
==============

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have port: clk  input  1  single clock, all state on rising edge.
REQ-002 SHALL have port: rst  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports: in_valid input 1, in_ready output 1; upstream handshake, transfer when both high.
REQ-004 SHALL have port: mem_op  input  4  encoding: 0 NONE, 1 LB, 2 LH, 3 LW, 4 LD, 5 LBU, 6 LHU, 7 LWU, 8 SB, 9 SH, 10 SW, 11 SD; others treated as NONE.
REQ-005 SHALL have ports: alu_result input 64 (execute result / effective address), store_data input 64, rd_addr_i input 5, rd_wen_i input 1.
REQ-006 SHALL have ports: dreq_valid output 1, dreq_ready input 1, dreq_addr output 64 (8-byte aligned), dreq_we output 1, dreq_wdata output 64, dreq_wmask output 8.
REQ-007 SHALL have ports: drsp_valid input 1, drsp_data input 64; one response per accepted request, loads and stores alike.
REQ-008 SHALL have ports: out_valid output 1, out_ready input 1, rd_data output 64, rd_addr_o output 5, rd_wen_o output 1, misalign output 1.

Function
REQ-009 SHALL implement FSM IDLE, REQ, WAIT, DONE; in_ready high only in IDLE, or in DONE when out_ready high (same-cycle refill).
REQ-010 SHALL, on accept of a NONE op, go to DONE next cycle with rd_data = alu_result, rd_addr/rd_wen copied; latency 1 cycle.
REQ-011 SHALL, on accept of a load/store, latch all inputs and go to REQ; dreq_valid high throughout REQ, fields stable until dreq_ready.
REQ-012 SHALL move REQ->WAIT on dreq_valid&dreq_ready, and WAIT->DONE on drsp_valid; drsp_valid outside WAIT ignored.
REQ-013 SHALL drive dreq_addr = {addr[63:3],3'b0}; dreq_we = 1 for stores only.
REQ-014 SHALL form store mask/data from size and addr[2:0]: SB 1 bit, SH 2 bits, SW 4 bits, SD 8'hFF, shifted by addr[2:0]; store_data replicated into lane position; dreq_wmask = 0 for loads.
REQ-015 SHALL extract load data by shifting drsp_data right by 8*addr[2:0], then sign-extend (LB/LH/LW) or zero-extend (LBU/LHU/LWU); LD unchanged.
REQ-016 SHALL hold out_valid high in DONE with stable outputs until out_ready; stores deliver rd_wen_o = 0.
REQ-017 SHALL leave DONE to IDLE on out_ready without new input, or to REQ/DONE on simultaneous out_ready and in_valid (back-to-back, no bubble).
REQ-018 SHALL ignore in_valid whenever in_ready is low; no input is lost or duplicated.

Reset
REQ-019 SHALL on rst low immediately force state IDLE, out_valid 0, dreq_valid 0, dreq_we 0, dreq_wmask 0, rd_wen_o 0, misalign 0, rd_data/rd_addr_o/dreq_addr/dreq_wdata 0.
REQ-020 SHALL abandon any in-flight request when reset asserts mid-operation; a late drsp_valid after reset release SHALL be ignored (state IDLE).

Configuration
REQ-021 SHALL, with MEM_MISALIGN_CHECK_EN defined, detect misalignment (H: addr[0]!=0, W: addr[1:0]!=0, D: addr[2:0]!=0), skip the bus, go directly to DONE with misalign 1, rd_wen_o 0, rd_data = alu_result.
REQ-022 SHALL, without MEM_MISALIGN_CHECK_EN, tie misalign to 0 and force natural alignment by clearing the offending low address bits before lane selection.

Verification
REQ-023 SHALL cover: NONE op, alu_result=64'h1234 -> out_valid next cycle, rd_data=64'h1234, no dreq_valid.
REQ-024 SHALL cover: LB addr=0x1003, drsp_data=64'h00000000_80000000 -> rd_data=64'hFFFFFFFF_FFFFFF80; LBU same -> 64'h80.
REQ-025 SHALL cover: SH addr=0x2006, store_data=16'hBEEF -> dreq_addr=0x2000, dreq_wmask=8'hC0, dreq_wdata[63:48]=16'hBEEF, rd_wen_o=0.
REQ-026 SHALL cover: dreq_ready held low 5 cycles, out_ready low 3 cycles in DONE -> request/outputs stable, single transaction, no drop.
REQ-027 SHALL cover: LW addr=0x1002 with MEM_MISALIGN_CHECK_EN -> misalign=1, no dreq_valid; without -> dreq_addr=0x1000, lane 0 word returned.
REQ-028 SHALL cover: rst low during WAIT, then drsp_valid after release -> state IDLE, out_valid stays 0.

Source files
------------

// File: rtl/mem_stage.sv
// Memory stage: issues one aligned 64-bit bus request per load/store and returns writeback data.
// Optional macro MEM_MISALIGN_CHECK_EN reports misaligned accesses instead of aligning them.
module mem_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  mem_op,
    input  logic [63:0] alu_result,
    input  logic [63:0] store_data,
    input  logic [4:0]  rd_addr_i,
    input  logic        rd_wen_i,
    output logic        dreq_valid,
    input  logic        dreq_ready,
    output logic [63:0] dreq_addr,
    output logic        dreq_we,
    output logic [63:0] dreq_wdata,
    output logic [7:0]  dreq_wmask,
    input  logic        drsp_valid,
    input  logic [63:0] drsp_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] rd_data,
    output logic [4:0]  rd_addr_o,
    output logic        rd_wen_o,
    output logic        misalign,
    output logic [1:0]  fsm_state
);

    // Every channel is valid/ready: a transfer happens on a rising edge where both are high,
    // and a producer holds valid and its payload stable until that edge.

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    state_t      state, state_nx;
    logic [3:0]  op_q;
    logic [63:0] addr_q;
    logic [63:0] sdata_q;
    logic [63:0] rd_data_q;
    logic [4:0]  rd_addr_q;
    logic        rd_wen_q;
    logic        mis_q;

    logic        accept;
    logic        in_is_load, in_is_store, in_skip, in_to_bus;
    logic        load_q, store_q;
    logic [1:0]  size_q;
    logic [2:0]  lane_off;
    logic [7:0]  byte_en;
    logic [63:0] wdata_rep;
    logic [63:0] ld_shift, ld_val;

    function automatic logic is_load(input logic [3:0] op);
        return (op >= 4'd1) && (op <= 4'd7);
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        return (op >= 4'd8) && (op <= 4'd11);
    endfunction

    // 0: byte, 1: half, 2: word, 3: double
    function automatic logic [1:0] op_size(input logic [3:0] op);
        case (op)
            4'd2, 4'd6, 4'd9:  return 2'd1;
            4'd3, 4'd7, 4'd10: return 2'd2;
            4'd4, 4'd11:       return 2'd3;
            default:           return 2'd0;
        endcase
    endfunction

    assign in_is_load  = is_load(mem_op);
    assign in_is_store = is_store(mem_op);

`ifdef MEM_MISALIGN_CHECK_EN
    logic in_mis;
    always_comb begin
        case (op_size(mem_op))
            2'd1:    in_mis = alu_result[0];
            2'd2:    in_mis = |alu_result[1:0];
            2'd3:    in_mis = |alu_result[2:0];
            default: in_mis = 1'b0;
        endcase
    end
    assign in_skip = (in_is_load | in_is_store) & in_mis;
`else
    assign in_skip = 1'b0;
`endif

    assign in_to_bus = (in_is_load | in_is_store) & ~in_skip;
    assign accept    = in_valid & in_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        in_ready = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nx = in_to_bus ? S_REQ : S_DONE;
            end
            S_REQ:  if (dreq_ready) state_nx = S_WAIT;
            S_WAIT: if (drsp_valid) state_nx = S_DONE;
            S_DONE: begin
                if (out_ready) begin
                    in_ready = 1'b1;
                    if (in_valid) state_nx = in_to_bus ? S_REQ : S_DONE;
                    else          state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Non-memory and skipped ops hand alu_result straight through; loads overwrite it on response.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_q      <= 4'd0;
            addr_q    <= 64'd0;
            sdata_q   <= 64'd0;
            rd_data_q <= 64'd0;
            rd_addr_q <= 5'd0;
            rd_wen_q  <= 1'b0;
            mis_q     <= 1'b0;
        end else if (accept) begin
            op_q      <= mem_op;
            addr_q    <= alu_result;
            sdata_q   <= store_data;
            rd_data_q <= alu_result;
            rd_addr_q <= rd_addr_i;
            rd_wen_q  <= rd_wen_i & ~in_is_store & ~in_skip;
            mis_q     <= in_skip;
        end else if (state == S_WAIT && drsp_valid && load_q) begin
            rd_data_q <= ld_val;
        end
    end

    assign load_q  = is_load(op_q);
    assign store_q = is_store(op_q);
    assign size_q  = op_size(op_q);

    // Low address bits below the access size are dropped, giving natural alignment.
    always_comb begin
        case (size_q)
            2'd0: begin lane_off = addr_q[2:0];         byte_en = 8'h01; wdata_rep = {8{sdata_q[7:0]}};  end
            2'd1: begin lane_off = {addr_q[2:1], 1'b0}; byte_en = 8'h03; wdata_rep = {4{sdata_q[15:0]}}; end
            2'd2: begin lane_off = {addr_q[2], 2'b00};  byte_en = 8'h0F; wdata_rep = {2{sdata_q[31:0]}}; end
            default: begin lane_off = 3'd0;             byte_en = 8'hFF; wdata_rep = sdata_q;            end
        endcase
    end

    always_comb begin
        ld_shift = drsp_data >> {lane_off, 3'b000};
        case (op_q)
            4'd1:    ld_val = {{56{ld_shift[7]}},  ld_shift[7:0]};
            4'd2:    ld_val = {{48{ld_shift[15]}}, ld_shift[15:0]};
            4'd3:    ld_val = {{32{ld_shift[31]}}, ld_shift[31:0]};
            4'd5:    ld_val = {56'd0, ld_shift[7:0]};
            4'd6:    ld_val = {48'd0, ld_shift[15:0]};
            4'd7:    ld_val = {32'd0, ld_shift[31:0]};
            default: ld_val = ld_shift;
        endcase
    end

    assign dreq_valid = (state == S_REQ);
    assign dreq_addr  = {addr_q[63:3], 3'b000};
    assign dreq_we    = dreq_valid & store_q;
    assign dreq_wmask = (dreq_valid & store_q) ? (byte_en << lane_off) : 8'h00;
    assign dreq_wdata = store_q ? wdata_rep : 64'd0;

    assign out_valid  = (state == S_DONE);
    assign rd_data    = rd_data_q;
    assign rd_addr_o  = rd_addr_q;
    assign rd_wen_o   = rd_wen_q;
    assign misalign   = mis_q;
    assign fsm_state  = state;

endmodule
